// File: rtl/palette_pkg.sv
// Shared definitions for the runtime palette loader: default geometry and FSM states.
package palette_pkg;

    localparam int PAL_LUT_SIZE   = 256;
    localparam int PAL_RBG_SIZE   = 24;
    localparam int PAL_DATA_WIDTH = 32;
    localparam int PAL_ADDR_W     = $clog2(PAL_LUT_SIZE);

    typedef enum logic [1:0] {
        PW_IDLE,
        PW_LOAD,
        PW_DRAIN,
        PW_SWAP
    } pw_state_t;

endpackage

// File: rtl/palette_writer.sv
// Streams one palette into the inactive bank of the double-banked palette RAM and
// flips bank_sel only after a frame of exactly LUT_SIZE entries.
module palette_writer
    import palette_pkg::*;
#(
    parameter int LUT_SIZE   = PAL_LUT_SIZE,
    parameter int RBG_SIZE   = PAL_RBG_SIZE,
    parameter int DATA_WIDTH = PAL_DATA_WIDTH
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_WIDTH-1:0]        s_data,
    input  logic                         s_valid,
    input  logic                         s_last,
    output logic                         s_ready,
    output logic                         wr_en,
    output logic [$clog2(LUT_SIZE):0]    wr_addr,
    output logic [RBG_SIZE-1:0]          wr_data,
    output logic                         bank_sel,
    output logic                         load_done,
    output logic                         err_short,
    output logic                         err_long
);

    localparam int               IDX_W    = $clog2(LUT_SIZE);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LUT_SIZE - 1);

    pw_state_t         state;
    logic [IDX_W-1:0]  idx;
    logic              accept;
    logic [RBG_SIZE-1:0] colour;
    logic              unused_data;

    // Handshake: a beat transfers on any rising edge where s_valid && s_ready; the host
    // holds s_data/s_last stable while s_valid is high and s_ready low. s_ready depends
    // only on state, so it is low exactly during the single SWAP cycle.
    assign s_ready     = (state != PW_SWAP);
    assign accept      = s_valid && s_ready;
    assign colour      = s_data[RBG_SIZE-1:0];
    assign unused_data = ^s_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PW_IDLE;
            idx       <= '0;
            bank_sel  <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            load_done <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            load_done <= 1'b0;
            err_short <= 1'b0;
            err_long  <= 1'b0;
            case (state)
                PW_IDLE, PW_LOAD: begin
                    if (accept) begin
                        // Every beat up to the last entry is written, even in a frame that
                        // later proves short; the inactive bank is never visible anyway.
                        wr_en   <= 1'b1;
                        wr_addr <= {~bank_sel, idx};
                        wr_data <= colour;
                        if (idx == LAST_IDX) begin
                            idx <= '0;
                            if (s_last) begin
                                state     <= PW_SWAP;
                                load_done <= 1'b1;
                            end else begin
                                state    <= PW_DRAIN;
                                err_long <= 1'b1;
                            end
                        end else if (s_last) begin
                            state     <= PW_IDLE;
                            idx       <= '0;
                            err_short <= 1'b1;
                        end else begin
                            state <= PW_LOAD;
                            idx   <= idx + IDX_W'(1);
                        end
                    end
                end
                PW_DRAIN: begin
                    if (accept && s_last) begin
                        state <= PW_IDLE;
                    end
                end
                PW_SWAP: begin
                    // The final write lands this cycle with the pre-flip bank in wr_addr.
                    bank_sel <= ~bank_sel;
                    idx      <= '0;
                    state    <= PW_IDLE;
                end
                default: begin
                    state <= PW_IDLE;
                    idx   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_palette_writer.sv
// Self-checking bench for palette_writer: table of frames, random data/gaps, and a
// frame-level reference model of which entries land in which bank.
module tb_palette_writer;
    import palette_pkg::*;

    localparam int LUT    = PAL_LUT_SIZE;
    localparam int RBG    = PAL_RBG_SIZE;
    localparam int DW     = PAL_DATA_WIDTH;
    localparam int IDX_W  = PAL_ADDR_W;
    localparam int ENT_W  = IDX_W + 1 + RBG;

    logic                 clk;
    logic                 reset;
    logic [DW-1:0]        s_data;
    logic                 s_valid;
    logic                 s_last;
    logic                 s_ready;
    logic                 wr_en;
    logic [IDX_W:0]       wr_addr;
    logic [RBG-1:0]       wr_data;
    logic                 bank_sel;
    logic                 load_done;
    logic                 err_short;
    logic                 err_long;

    palette_writer #(
        .LUT_SIZE   (LUT),
        .RBG_SIZE   (RBG),
        .DATA_WIDTH (DW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .bank_sel  (bank_sel),
        .load_done (load_done),
        .err_short (err_short),
        .err_long  (err_long)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Reference model state
    logic [ENT_W-1:0] exp_q[$];
    logic [DW-1:0]    fd[$];
    logic             model_bank = 1'b0;

    // Monitor counters
    bit mon_en        = 1'b0;
    int wr_cnt        = 0;
    int done_cnt      = 0;
    int short_cnt     = 0;
    int long_cnt      = 0;
    int ready_low_cnt = 0;
    int ready_bad     = 0;

    typedef struct {
        int beats;
        int gap;
        bit pattern;
        int exp_writes;
        int exp_done;
        int exp_short;
        int exp_long;
    } vec_t;

    vec_t vecs[10];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic monitor();
        logic [ENT_W-1:0] e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (wr_en === 1'b1) begin
                    wr_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_write got addr=%0h data=%0h expected no write",
                                 wr_addr, wr_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("write_addr_data", 64'({wr_addr, wr_data}), 64'(e));
                    end
                end
                if (load_done === 1'b1) done_cnt++;
                if (err_short === 1'b1) short_cnt++;
                if (err_long === 1'b1)  long_cnt++;
                if (s_ready !== 1'b1) begin
                    ready_low_cnt++;
                    if (load_done !== 1'b1) ready_bad++;
                end
            end
        end
    endtask

    // Frame-level model: the first min(n, LUT) beats go to the inactive bank at index i;
    // only an exactly LUT-sized frame flips the visible bank.
    task automatic model_frame(input int n, input bit pattern);
        logic [DW-1:0] d;
        fd.delete();
        for (int i = 0; i < n; i++) begin
            d = pattern ? DW'(i * 32'h0001_0101) : DW'($urandom);
            fd.push_back(d);
            if (i < LUT) exp_q.push_back({~model_bank, IDX_W'(i), d[RBG-1:0]});
        end
        if (n == LUT) model_bank = ~model_bank;
    endtask

    // Called #1 after a rising edge; returns #1 after the edge that accepted the beat.
    task automatic drive_beat(input logic [DW-1:0] d, input bit l, input int gap);
        int waited;
        while ($urandom_range(0, 99) < gap) begin
            s_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        waited  = 0;
        while (1) begin
            @(negedge clk);
            if (s_ready === 1'b1) begin
                @(posedge clk);
                #1;
                break;
            end
            @(posedge clk);
            #1;
            waited++;
            if (waited > 20) begin
                checks++;
                failures++;
                $display("FAIL ready_timeout got s_ready=%b for %0d cycles expected 1", s_ready, waited);
                break;
            end
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic drive_frame(input int n_drive, input int n_total, input int gap);
        for (int i = 0; i < n_drive; i++) begin
            drive_beat(fd[i], (i == n_total - 1), gap);
        end
    endtask

    task automatic settle();
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w0, d0, s0, l0;
        vecs[0] = '{256, 0,  1'b1, 256, 1, 0, 0};
        vecs[1] = '{256, 0,  1'b1, 256, 1, 0, 0};
        vecs[2] = '{10,  0,  1'b0, 10,  0, 1, 0};
        vecs[3] = '{256, 0,  1'b0, 256, 1, 0, 0};
        vecs[4] = '{300, 0,  1'b0, 256, 0, 0, 1};
        vecs[5] = '{256, 50, 1'b0, 256, 1, 0, 0};
        vecs[6] = '{1,   0,  1'b0, 1,   0, 1, 0};
        vecs[7] = '{255, 30, 1'b0, 255, 0, 1, 0};
        vecs[8] = '{257, 20, 1'b0, 256, 0, 0, 1};
        vecs[9] = '{256, 30, 1'b0, 256, 1, 0, 0};

        reset   = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        s_last  = 1'b0;
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1;
        reset  = 1'b0;
        mon_en = 1'b1;

        @(negedge clk);
        check("reset_wr_en",     64'(wr_en),     64'(0));
        check("reset_wr_addr",   64'(wr_addr),   64'(0));
        check("reset_wr_data",   64'(wr_data),   64'(0));
        check("reset_bank_sel",  64'(bank_sel),  64'(0));
        check("reset_load_done", 64'(load_done), 64'(0));
        check("reset_err_short", 64'(err_short), 64'(0));
        check("reset_err_long",  64'(err_long),  64'(0));
        check("reset_s_ready",   64'(s_ready),   64'(1));
        @(posedge clk);
        #1;

        for (int v = 0; v < 10; v++) begin
            w0 = wr_cnt;
            d0 = done_cnt;
            s0 = short_cnt;
            l0 = long_cnt;
            model_frame(vecs[v].beats, vecs[v].pattern);
            drive_frame(vecs[v].beats, vecs[v].beats, vecs[v].gap);
            settle();
            check($sformatf("v%0d_writes", v),    64'(wr_cnt - w0),    64'(vecs[v].exp_writes));
            check($sformatf("v%0d_load_done", v), 64'(done_cnt - d0),  64'(vecs[v].exp_done));
            check($sformatf("v%0d_err_short", v), 64'(short_cnt - s0), 64'(vecs[v].exp_short));
            check($sformatf("v%0d_err_long", v),  64'(long_cnt - l0),  64'(vecs[v].exp_long));
            check($sformatf("v%0d_bank_sel", v),  64'(bank_sel),       64'(model_bank));
            check($sformatf("v%0d_pending", v),   64'(exp_q.size()),   64'(0));
        end

        // Reset arrives while beat 100 of a frame would be next: beat 99 still writes,
        // then nothing, and the visible bank returns to 0.
        fd.delete();
        for (int i = 0; i < 100; i++) begin
            fd.push_back(DW'($urandom));
            exp_q.push_back({~model_bank, IDX_W'(i), fd[i][RBG-1:0]});
        end
        d0 = done_cnt;
        drive_frame(100, LUT, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("midreset_wr_en",     64'(wr_en),     64'(0));
        check("midreset_bank_sel",  64'(bank_sel),  64'(0));
        check("midreset_load_done", 64'(done_cnt - d0), 64'(0));
        check("midreset_pending",   64'(exp_q.size()), 64'(0));
        reset      = 1'b0;
        model_bank = 1'b0;
        @(posedge clk);
        #1;

        w0 = wr_cnt;
        model_frame(LUT, 1'b0);
        drive_frame(LUT, LUT, 25);
        settle();
        check("after_reset_writes",   64'(wr_cnt - w0),  64'(LUT));
        check("after_reset_bank_sel", 64'(bank_sel),     64'(1));
        check("after_reset_pending",  64'(exp_q.size()), 64'(0));

        check("ready_low_outside_swap", 64'(ready_bad),     64'(0));
        check("ready_low_cycles",       64'(ready_low_cnt), 64'(done_cnt));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
